// File: rtl/audio_pwm_out.sv
// Audio sample sink: synchronizes the processor's R6/R14 strobe, buffers samples in a FIFO
// and plays them as PWM duty cycles. Define AUDIO_SIGMA_DELTA_EN for a sigma-delta output stage.
module audio_pwm_out #(
    parameter int SAMPLE_W    = 11,
    parameter int FIFO_DEPTH  = 8,
    parameter int PRIME_LEVEL = 4,
    parameter int REPEAT      = 1
) (
    input  logic                clkFPGA,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] R6_audio,
    input  logic                R14_flag,
    input  logic                enable,
    output logic                pwm_out,
    output logic                fifo_full,
    output logic                overflow,
    output logic                underrun,
    output logic                playing
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [SAMPLE_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]          REP_LAST = 8'(REPEAT - 1);
    localparam logic [AW:0]         DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]         PRIME_C  = (AW + 1)'(PRIME_LEVEL);

    typedef enum logic {FILL, PLAY} state_t;

    // Reset asserts asynchronously but leaves reset in step with clkFPGA.
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) rst_pipe <= 2'b00;
        else      rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_n = rst_pipe[1];

    // The processor holds R6 stable from before the flag rises, so stage-2 data is
    // settled by the time stage 2 of the flag shows the edge.
    logic [2:0]          flag_sync;
    logic [SAMPLE_W-1:0] data_s1;
    logic [SAMPLE_W-1:0] data_s2;
    logic                flag_rise;

    always_ff @(posedge clkFPGA or negedge rst_n) begin
        if (!rst_n) begin
            flag_sync <= '0;
            data_s1   <= '0;
            data_s2   <= '0;
        end else begin
            flag_sync <= {flag_sync[1:0], R14_flag};
            data_s1   <= R6_audio;
            data_s2   <= data_s1;
        end
    end

    assign flag_rise = flag_sync[1] & ~flag_sync[2];

    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                prime_ok;
    logic                pop_point;
    logic                wrap;

    state_t              state;
    logic [SAMPLE_W-1:0] pwm_cnt;
    logic [7:0]          rep_cnt;
    logic [SAMPLE_W-1:0] cur_sample;
    logic                pwm_q;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        fifo_empty = (count == '0);
        full       = (count == DEPTH_C);
        wrap       = (pwm_cnt == CNT_MAX);
        prime_ok   = (state == FILL) && enable && (count >= PRIME_C);
        pop_point  = (state == PLAY) && enable && wrap && (rep_cnt == REP_LAST);
        pop        = prime_ok || (pop_point && !fifo_empty);
        push       = flag_rise && (!full || pop);
    end

    always_ff @(posedge clkFPGA) begin
        if (push) mem[wr_ptr] <= data_s2;
    end

    always_ff @(posedge clkFPGA or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (flag_rise && !push) overflow <= 1'b1;
        end
    end

`ifdef AUDIO_SIGMA_DELTA_EN
    logic [SAMPLE_W:0] acc;
    logic [SAMPLE_W:0] acc_next;

    always_comb begin
        acc_next = {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, cur_sample};
    end
`endif

    always_ff @(posedge clkFPGA or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            pwm_cnt    <= '0;
            rep_cnt    <= '0;
            cur_sample <= '0;
            pwm_q      <= 1'b0;
            underrun   <= 1'b0;
`ifdef AUDIO_SIGMA_DELTA_EN
            acc        <= '0;
`endif
        end else begin
            case (state)
                FILL: begin
                    pwm_q <= 1'b0;
                    if (prime_ok) begin
                        cur_sample <= mem[rd_ptr];
                        pwm_cnt    <= '0;
                        rep_cnt    <= '0;
                        state      <= PLAY;
`ifdef AUDIO_SIGMA_DELTA_EN
                        acc        <= '0;
`endif
                    end
                end
                PLAY: begin
                    if (!enable) begin
                        pwm_q <= 1'b0;
                    end else begin
                        pwm_cnt <= pwm_cnt + 1'b1;
`ifdef AUDIO_SIGMA_DELTA_EN
                        acc     <= acc_next;
                        pwm_q   <= acc_next[SAMPLE_W];
`else
                        pwm_q   <= (pwm_cnt < cur_sample);
`endif
                        if (wrap) begin
                            if (rep_cnt == REP_LAST) begin
                                rep_cnt <= '0;
                                if (!fifo_empty) begin
                                    cur_sample <= mem[rd_ptr];
                                end else begin
                                    underrun <= 1'b1;
                                    state    <= FILL;
                                    pwm_q    <= 1'b0;
                                end
                            end else begin
                                rep_cnt <= rep_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign pwm_out   = pwm_q;
    assign fifo_full = full;
    assign playing   = (state == PLAY);

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out: priming, duty, overflow, input sync, pause and reset.
module tb_audio_pwm_out;

    localparam int PERIOD = 2048;

    logic        clkFPGA = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] R6_audio = '0;
    logic        R14_flag = 1'b0;
    logic        enable = 1'b0;
    logic        pwm_out;
    logic        fifo_full;
    logic        overflow;
    logic        underrun;
    logic        playing;

    int n_checks = 0;
    int n_fail = 0;

    audio_pwm_out dut (
        .clkFPGA  (clkFPGA),
        .rst      (rst),
        .R6_audio (R6_audio),
        .R14_flag (R14_flag),
        .enable   (enable),
        .pwm_out  (pwm_out),
        .fifo_full(fifo_full),
        .overflow (overflow),
        .underrun (underrun),
        .playing  (playing)
    );

    always #5 clkFPGA = ~clkFPGA;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        R14_flag = 1'b0;
        enable   = 1'b0;
        R6_audio = '0;
        #2;
        rst = 1'b0;
        repeat (4) @(negedge clkFPGA);
        rst = 1'b1;
        repeat (4) @(negedge clkFPGA);
    endtask

    // Processor-side write: R6 first, then R14 held for two processor cycles (4 clkFPGA each).
    task automatic push_sample(input logic [10:0] v);
        @(negedge clkFPGA);
        R6_audio = v;
        repeat (4) @(negedge clkFPGA);
        R14_flag = 1'b1;
        repeat (8) @(negedge clkFPGA);
        R14_flag = 1'b0;
        repeat (8) @(negedge clkFPGA);
    endtask

    task automatic measure_period(output int hi);
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clkFPGA);
            if (pwm_out === 1'b1) hi++;
        end
    endtask

    task automatic test_reset_state();
        apply_reset();
        n_checks++;
        if ({pwm_out, fifo_full, overflow, underrun, playing} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_state: outputs=%b expected=00000",
                     {pwm_out, fifo_full, overflow, underrun, playing});
        end
    endtask

    task automatic test_priming();
        logic got;
        apply_reset();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_sample(11'(100 * (i + 1)));
            n_checks++;
            if (playing !== 1'b0) begin
                n_fail++;
                $display("FAIL prime_hold[%0d]: playing=%b expected=0", i, playing);
            end
        end
        @(negedge clkFPGA);
        R6_audio = 11'd400;
        repeat (4) @(negedge clkFPGA);
        R14_flag = 1'b1;
        got = 1'b0;
        // 3 cycles of capture latency plus 2 cycles for the FSM to start.
        for (int k = 0; k < 5; k++) begin
            @(negedge clkFPGA);
            if (playing === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (got !== 1'b1) begin
            n_fail++;
            $display("FAIL prime_start: playing=%b expected=1 within 5 cycles of flag", playing);
        end
        R14_flag = 1'b0;
        repeat (8) @(negedge clkFPGA);
    endtask

    task automatic test_duty();
        logic [10:0] vals [4];
        int hi;
        vals = '{11'd0, 11'd512, 11'd2047, 11'd1024};
        apply_reset();
        for (int i = 0; i < 4; i++) push_sample(vals[i]);
        enable = 1'b1;
        @(negedge clkFPGA);
        n_checks++;
        if (playing !== 1'b1) begin
            n_fail++;
            $display("FAIL duty_start: playing=%b expected=1", playing);
        end
        for (int i = 0; i < 4; i++) begin
            measure_period(hi);
            n_checks++;
            if (hi !== int'(vals[i])) begin
                n_fail++;
                $display("FAIL duty[%0d]: high=%0d expected=%0d", i, hi, vals[i]);
            end
            if (i < 3) begin
                n_checks++;
                if (underrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL duty_no_underrun[%0d]: underrun=%b expected=0", i, underrun);
                end
            end
        end
        n_checks++;
        if ({underrun, playing, pwm_out} !== 3'b100) begin
            n_fail++;
            $display("FAIL duty_underrun: {underrun,playing,pwm}=%b expected=100",
                     {underrun, playing, pwm_out});
        end
    endtask

    task automatic test_overflow();
        int hi;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            push_sample((i < 8) ? 11'(100 + 200 * i) : 11'd2000);
            if (i == 6) begin
                n_checks++;
                if (fifo_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_not_full: fifo_full=%b expected=0", fifo_full);
                end
            end
            if (i == 7) begin
                n_checks++;
                if ({fifo_full, overflow} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL ovf_full: {full,ovf}=%b expected=10", {fifo_full, overflow});
                end
            end
            if (i == 8) begin
                n_checks++;
                if ({fifo_full, overflow} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL ovf_set: {full,ovf}=%b expected=11", {fifo_full, overflow});
                end
            end
        end
        enable = 1'b1;
        @(negedge clkFPGA);
        for (int i = 0; i < 8; i++) begin
            measure_period(hi);
            n_checks++;
            if (hi !== 100 + 200 * i) begin
                n_fail++;
                $display("FAIL ovf_order[%0d]: high=%0d expected=%0d", i, hi, 100 + 200 * i);
            end
        end
        n_checks++;
        if ({underrun, playing} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_ninth_dropped: {underrun,playing}=%b expected=10",
                     {underrun, playing});
        end
    endtask

    task automatic test_sync_edges();
        int hi;
        apply_reset();
        @(negedge clkFPGA);
        R6_audio = 11'd300;
        repeat (4) @(negedge clkFPGA);
        R14_flag = 1'b1;
        repeat (50) @(negedge clkFPGA);
        R14_flag = 1'b0;
        repeat (8) @(negedge clkFPGA);
        R6_audio = 11'd200;
        repeat (4) @(negedge clkFPGA);
        R14_flag = 1'b1;
        repeat (8) @(negedge clkFPGA);
        R6_audio = 11'd1900;
        repeat (8) @(negedge clkFPGA);
        R14_flag = 1'b0;
        repeat (8) @(negedge clkFPGA);
        push_sample(11'd700);
        enable = 1'b1;
        repeat (10) @(negedge clkFPGA);
        n_checks++;
        if (playing !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_single_push: playing=%b expected=0 with 3 samples", playing);
        end
        enable = 1'b0;
        push_sample(11'd1000);
        enable = 1'b1;
        @(negedge clkFPGA);
        n_checks++;
        if (playing !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_start: playing=%b expected=1", playing);
        end
        measure_period(hi);
        n_checks++;
        if (hi !== 300) begin
            n_fail++;
            $display("FAIL sync_held_flag: high=%0d expected=300", hi);
        end
        measure_period(hi);
        n_checks++;
        if (hi !== 200) begin
            n_fail++;
            $display("FAIL sync_data_capture: high=%0d expected=200", hi);
        end
        measure_period(hi);
        n_checks++;
        if (hi !== 700) begin
            n_fail++;
            $display("FAIL sync_third: high=%0d expected=700", hi);
        end
    endtask

    task automatic test_pause();
        int hi;
        int bad;
        apply_reset();
        push_sample(11'd1500);
        push_sample(11'd600);
        push_sample(11'd300);
        push_sample(11'd900);
        enable = 1'b1;
        @(negedge clkFPGA);
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clkFPGA);
            if (pwm_out === 1'b1) hi++;
        end
        n_checks++;
        if (hi !== 1000) begin
            n_fail++;
            $display("FAIL pause_before: high=%0d expected=1000", hi);
        end
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clkFPGA);
            if (pwm_out !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL pause_low: high_cycles=%0d expected=0", bad);
        end
        n_checks++;
        if (playing !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_playing: playing=%b expected=1", playing);
        end
        enable = 1'b1;
        hi = 0;
        for (int i = 0; i < PERIOD - 1000; i++) begin
            @(negedge clkFPGA);
            if (pwm_out === 1'b1) hi++;
        end
        n_checks++;
        if (hi !== 500) begin
            n_fail++;
            $display("FAIL pause_resume: high=%0d expected=500", hi);
        end
        measure_period(hi);
        n_checks++;
        if (hi !== 600) begin
            n_fail++;
            $display("FAIL pause_next_sample: high=%0d expected=600", hi);
        end
    endtask

    task automatic test_reset_mid_play();
        apply_reset();
        for (int i = 0; i < 9; i++) push_sample(11'd2047);
        enable = 1'b1;
        repeat (100) @(negedge clkFPGA);
        n_checks++;
        if ({playing, pwm_out, overflow} !== 3'b111) begin
            n_fail++;
            $display("FAIL rst_pre: {playing,pwm,ovf}=%b expected=111", {playing, pwm_out, overflow});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({pwm_out, playing, overflow, underrun, fifo_full} !== 5'b00000) begin
            n_fail++;
            $display("FAIL rst_async: {pwm,play,ovf,udr,full}=%b expected=00000",
                     {pwm_out, playing, overflow, underrun, fifo_full});
        end
        repeat (3) @(negedge clkFPGA);
        rst = 1'b1;
        repeat (4) @(negedge clkFPGA);
        for (int i = 0; i < 3; i++) push_sample(11'd50);
        repeat (4) @(negedge clkFPGA);
        n_checks++;
        if ({playing, overflow, fifo_full} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_fifo_empty: {play,ovf,full}=%b expected=000",
                     {playing, overflow, fifo_full});
        end
    endtask

    initial begin
        test_reset_state();
        test_priming();
        test_duty();
        test_overflow();
        test_sync_edges();
        test_pause();
        test_reset_mid_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_pwm_out.md
Name: audio_pwm_out

Overview:
- Consumer end of the processor's audio interface: accepts the R6_audio sample word and R14_flag "sample ready" strobe produced by the datapath.
- Buffers samples in a small FIFO and plays each one as a PWM duty cycle on a single pin.
- Runs on clkFPGA; the processor runs on a derived slower clock, so all processor-side inputs are treated as asynchronous-slow.

Parameters:
- SAMPLE_W, 11, sample width in bits; PWM period is 2^SAMPLE_W clkFPGA cycles.
- FIFO_DEPTH, 8, sample FIFO entries (power of two).
- PRIME_LEVEL, 4, FIFO occupancy required before playback starts or resumes.
- REPEAT, 1, PWM periods each sample is held (1..255).

Ports:
- clkFPGA  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- R6_audio  in  SAMPLE_W  sample word from processor register R6.
- R14_flag  in  1  sample-ready flag from processor register R14; a new sample on each 0->1 transition.
- enable  in  1  playback enable; 0 forces pwm_out low and freezes the consumer side.
- pwm_out  out  1  audio PWM output.
- fifo_full  out  1  FIFO occupancy == FIFO_DEPTH.
- overflow  out  1  sticky: a sample arrived while the FIFO was full.
- underrun  out  1  sticky: a sample was needed while the FIFO was empty during PLAY.
- playing  out  1  FSM in PLAY.

Behaviour:
- Reset (async assert, sync deassert internally): pwm_out=0, fifo_full=0, overflow=0, underrun=0, playing=0, FIFO empty, FSM=FILL, PWM counter=0, current sample=0.
- Input sync:
  - R14_flag and R6_audio each pass through a 2-flop synchronizer.
  - Rising edge = sync_flag stage2 & ~stage3.
  - The sample pushed is the stage-2 data captured in the same cycle.
  - Processor contract: R6 is written at least one processor cycle before R14 is set.
  - Capture latency: 3 clkFPGA cycles from the flag edge to the FIFO push.
- Push:
  - One push per rising edge.
  - If the FIFO is full, the sample is dropped and overflow is set.
  - Push is independent of enable.
- FSM:
  - FILL: playing=0, pwm_out=0. When occupancy >= PRIME_LEVEL and enable=1, pop into the current sample, clear the PWM counter and repeat counter, and go to PLAY.
  - PLAY: playing=1. The PWM counter counts 0..2^SAMPLE_W-1 and wraps. pwm_out = (cnt < current_sample), registered, so there is 1 cycle of output latency.
  - At each wrap, the repeat counter increments. When it reaches REPEAT, it clears and a new sample is popped.
  - If the FIFO is empty at a pop point: set underrun, go to FILL, and drive pwm_out low from the next cycle.
  - enable=0 in PLAY: pwm_out=0, counters hold, no pops. Playback resumes from the held position when enable returns to 1.
- Duty rules:
  - Sample 0 gives a constant low output.
  - Sample 2^SAMPLE_W-1 is high for all but 1 cycle per period.
  - Samples are unsigned.
- Simultaneous push and pop in the same cycle: both take effect. Occupancy is unchanged, and a full FIFO does not overflow in that case.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a (log2 FIFO_DEPTH + 1)-bit counter.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: AUDIO_SIGMA_DELTA_EN.
- Defined:
  - pwm_out is driven by a first-order sigma-delta modulator instead of the comparator.
  - Accumulator is SAMPLE_W+1 bits: acc <= acc[SAMPLE_W-1:0] + current_sample; pwm_out = acc carry bit.
  - The accumulator is cleared on reset and on FILL->PLAY.
  - Sample timing (PWM counter, REPEAT, pops) is unchanged.
- Undefined: comparator PWM as described in Behaviour.

Test Plan:
- Reset: assert rst=0 mid-PLAY -> pwm_out, playing, overflow and underrun are 0 immediately; FIFO empty after release.
- Priming: enable=1, push 3 samples -> playing stays 0. On the 4th push, playing=1 within 2 cycles.
- Duty, with samples 0, 512, 2047, 1024 and REPEAT=1:
  - high counts per 2048-cycle period are exactly 0, 512, 2047 and 1024.
  - the 5th pop point with no further pushes sets underrun=1, playing=0 and pwm_out=0.
- Overflow: enable=0, push 9 samples -> fifo_full=1 after the 8th, overflow=1 after the 9th. Playback then outputs the first 8 samples in order; the 9th never appears.
- Sync/edges:
  - holding R14_flag high for 50 cycles gives exactly 1 push.
  - R6_audio is changed 2 processor cycles after the flag rises -> the originally written value is played.
- Pause: drop enable for 300 cycles mid-period -> pwm_out=0 throughout, and the period resumes at the same counter value with no sample skipped.
